ct_match_sched: RTL
===================

// Module: ct_match_sched
// PURPOSE
//  Sequences secret-vs-candidate comparisons with data-independent timing (CWE-203 mitigation).
//  - Accepts candidates over a valid/ready handshake.
//  - Runs every compare for exactly CMP_CYCLES, whether it matches or not.
//  - Returns match/locked status at a fixed latency.
//  - Sits between the host request bus and the secret comparison datapath.
// PARAMETERS
//  DATA_W      8    width of secret and candidate
//  CMP_CYCLES  10   fixed compare duration in cycles, >=1
//  MAX_FAILS   3    consecutive mismatches that trigger lockout (CMP_LOCKOUT_EN only)
//  LOCK_CYCLES 256  lockout duration in cycles (CMP_LOCKOUT_EN only)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  secret_we    in   1       load secret_in into the secret register
//  secret_in    in   DATA_W  new secret value
//  req_valid    in   1       candidate valid
//  req_ready    out  1       scheduler can accept a candidate
//  req_data     in   DATA_W  candidate value
//  rsp_valid    out  1       one-cycle response strobe
//  rsp_match    out  1       candidate equalled secret; qualified by rsp_valid
//  rsp_locked   out  1       request was refused because of lockout; qualified by rsp_valid
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset
//   - All outputs 0 except req_ready=1.
//   - Secret=0, secret_loaded=0, fail count=0, state=IDLE.
//   - A reset mid-compare or mid-lockout aborts it; no response is issued.
//  FSM: IDLE -> CMP -> RSP -> IDLE | LOCK
//   - IDLE: req_ready=1. On req_valid&&req_ready, latch req_data and go to CMP with cyc=0.
//   - CMP: XOR candidate with secret into a sticky diff register.
//     - Advance cyc every cycle; leave when cyc==CMP_CYCLES-1.
//     - There is no early exit on mismatch or on match.
//   - RSP: rsp_valid=1 for exactly one cycle. rsp_match=(diff==0)&&secret_loaded.
//  Latency
//   - rsp_valid rises exactly CMP_CYCLES+1 cycles after the accepting edge, for every input.
//  Timing independence
//   - Path, cycle count and req_ready pattern do not depend on candidate or secret values.
//  Secret write
//   - Honoured only in IDLE when no handshake occurs in the same cycle.
//   - Ignored in any other state.
//   - Sets secret_loaded=1.
//   - If secret_we and a handshake coincide, the handshake wins and the write is dropped.
//  No secret loaded
//   - A compare still runs the full CMP_CYCLES.
//   - rsp_match=0, and the result counts as a mismatch.
//  Back-to-back
//   - req_ready is 0 during CMP and RSP.
//   - At most one request every CMP_CYCLES+2 cycles.
//  Outputs are registered, with no combinational path from req_data or secret to any output.
// CONFIGURATION
//  CMP_LOCKOUT_EN defined
//   - fail_cnt is a saturating counter of width $clog2(MAX_FAILS+1).
//     - A mismatch increments it.
//     - A match clears it.
//   - In RSP, when the mismatch makes fail_cnt==MAX_FAILS:
//     - go to LOCK instead of IDLE, with a lock counter of LOCK_CYCLES.
//   - In LOCK:
//     - req_ready=1; each accepted request is dropped.
//     - Issue rsp_valid with rsp_locked=1, rsp_match=0, at the same CMP_CYCLES+1 latency, driven by a shadow cycle counter.
//     - The lock counter keeps running during shadow compares.
//   - When the lock counter reaches 0 (and no shadow is pending): fail_cnt=0, go to IDLE.
//   - A shadow in flight at expiry completes its response first.
//  CMP_LOCKOUT_EN undefined
//   - No fail/lock counters; LOCK is unreachable.
//   - rsp_locked is tied to 0.
// STRUCTURE
//  Package ct_match_pkg
//   - state enum {IDLE, CMP, RSP, LOCK}.
//   - localparam helper for counter widths ($clog2).
//  One sub-module, ct_match_core
//   - Holds the secret register, candidate latch and sticky diff accumulator.
//   - Enabled by the FSM; exposes only diff_zero.
//  FSM and counters live in ct_match_sched.
// TESTING
//  1. Load 8'hA5, request 8'hA5 -> rsp_valid at +11 cycles, rsp_match=1, rsp_locked=0.
//  2. Load 8'hA5, request 8'h5A and 8'hA4 -> each rsp_valid at exactly +11, match=0; identical req_ready/busy traces to test 1.
//  3. No secret loaded, request 8'h00 -> rsp_valid at +11, rsp_match=0.
//  4. [LOCKOUT_EN] 3 mismatches -> state LOCK.
//     - Request 8'hA5 (correct) -> +11 rsp_locked=1, match=0.
//     - After 256 cycles, request 8'hA5 -> match=1.
//  5. secret_we=1 with 8'h11 during CMP -> ignored; the next compare with the old secret matches.
//     - secret_we coincident with a handshake -> write dropped.
//  6. Assert rst at cycle 5 of CMP -> no rsp_valid; the next cycle shows req_ready=1, busy=0, secret_loaded=0.

Source files
------------

// File: rtl/ct_match_pkg.sv
// Shared types and sizing helpers for the constant-time match scheduler.
package ct_match_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RSP  = 2'd2,
    LOCK = 2'd3
  } state_e;

  // Bits needed for a counter holding 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ct_match_core.sv
// Secret register, candidate latch and sticky XOR-difference accumulator.
module ct_match_core
  import ct_match_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              secret_we_i,
  input  logic [DATA_W-1:0] secret_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] cand_i,
  input  logic              cmp_en_i,
  output logic              diff_zero_o
);

  logic [DATA_W-1:0] secret_q;
  logic [DATA_W-1:0] cand_q;
  logic [DATA_W-1:0] diff_q;

  // NOTE: the secret is reset as well, so a compare after reset can never see stale key material.
  always_ff @(posedge clk) begin
    if (rst) begin
      secret_q <= '0;
      cand_q   <= '0;
      diff_q   <= '0;
    end else begin
      if (secret_we_i) secret_q <= secret_i;
      if (load_i) begin
        cand_q <= cand_i;
        diff_q <= '0;
      end else if (cmp_en_i) begin
        diff_q <= diff_q | (cand_q ^ secret_q);
      end
    end
  end

  assign diff_zero_o = (diff_q == '0);

endmodule

// File: rtl/ct_match_sched.sv
// Fixed-latency secret compare scheduler; optional lockout under `CMP_LOCKOUT_EN.
// Every compare takes CMP_CYCLES cycles and responds CMP_CYCLES+1 cycles after acceptance.
module ct_match_sched
  import ct_match_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CMP_CYCLES  = 10,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              secret_we,
  input  logic [DATA_W-1:0] secret_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_match,
  output logic              rsp_locked,
  output logic              busy
);

  localparam int CYC_W = cnt_w(CMP_CYCLES + 1);

  state_e           state_q;
  logic [CYC_W-1:0] cyc_q;
  logic             secret_loaded_q;
  logic             req_ready_q, rsp_valid_q, rsp_match_q, busy_q;
  logic             accept, match, diff_zero, core_load, core_secret_we, cmp_last;

  assign accept   = req_valid && req_ready_q;
  assign match    = diff_zero && secret_loaded_q;
  assign cmp_last = (cyc_q == CYC_W'(CMP_CYCLES - 1));

`ifdef CMP_LOCKOUT_EN
  localparam int FAIL_W = cnt_w(MAX_FAILS + 1);
  localparam int LOCK_W = cnt_w(LOCK_CYCLES + 1);

  logic [FAIL_W-1:0] fail_cnt_q;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CYC_W-1:0]  sh_cyc_q;
  logic              sh_act_q, rsp_locked_q, lock_exit, last_fail;

  assign lock_cnt_d = (lock_cnt_q != '0) ? lock_cnt_q - LOCK_W'(1) : lock_cnt_q;
  assign lock_exit  = (state_q == LOCK) && !sh_act_q && (lock_cnt_d == '0);
  assign last_fail  = (fail_cnt_q == FAIL_W'(MAX_FAILS - 1));
  // A request arriving on the expiry cycle is served as a real compare.
  assign core_load  = accept && ((state_q == IDLE) || lock_exit);
  assign rsp_locked = rsp_locked_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{MAX_FAILS[0], LOCK_CYCLES[0]};
  assign core_load  = accept && (state_q == IDLE);
  assign rsp_locked = 1'b0;
`endif

  assign core_secret_we = (state_q == IDLE) && secret_we && !accept;

  ct_match_core #(.DATA_W(DATA_W)) u_core (
    .clk        (clk),
    .rst        (rst),
    .secret_we_i(core_secret_we),
    .secret_i   (secret_in),
    .load_i     (core_load),
    .cand_i     (req_data),
    .cmp_en_i   (state_q == CMP),
    .diff_zero_o(diff_zero)
  );

  // NOTE: all state and registered outputs update with <= so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cyc_q           <= '0;
      secret_loaded_q <= 1'b0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_match_q     <= 1'b0;
      busy_q          <= 1'b0;
`ifdef CMP_LOCKOUT_EN
      rsp_locked_q    <= 1'b0;
      fail_cnt_q      <= '0;
      lock_cnt_q      <= '0;
      sh_cyc_q        <= '0;
      sh_act_q        <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_match_q <= 1'b0;
`ifdef CMP_LOCKOUT_EN
      rsp_locked_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= CMP;
            cyc_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end else if (secret_we) begin
            secret_loaded_q <= 1'b1;
          end
        end
        CMP: begin
          cyc_q <= cyc_q + CYC_W'(1);
          if (cmp_last) state_q <= RSP;
        end
        RSP: begin
          rsp_valid_q <= 1'b1;
          rsp_match_q <= match;
          req_ready_q <= 1'b1;
`ifdef CMP_LOCKOUT_EN
          if (match) fail_cnt_q <= '0;
          else if (fail_cnt_q != FAIL_W'(MAX_FAILS)) fail_cnt_q <= fail_cnt_q + FAIL_W'(1);
          if (!match && last_fail) begin
            state_q    <= LOCK;
            lock_cnt_q <= LOCK_W'(LOCK_CYCLES);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
`ifdef CMP_LOCKOUT_EN
        LOCK: begin
          lock_cnt_q <= lock_cnt_d;
          if (sh_act_q) begin
            // Shadow compare: same ready/valid timing as a real one, data ignored.
            sh_cyc_q <= sh_cyc_q + CYC_W'(1);
            if (sh_cyc_q == CYC_W'(CMP_CYCLES)) begin
              sh_act_q     <= 1'b0;
              rsp_valid_q  <= 1'b1;
              rsp_locked_q <= 1'b1;
              req_ready_q  <= 1'b1;
            end
          end else if (lock_exit) begin
            fail_cnt_q <= '0;
            if (accept) begin
              state_q     <= CMP;
              cyc_q       <= '0;
              req_ready_q <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (accept) begin
            sh_act_q    <= 1'b1;
            sh_cyc_q    <= '0;
            req_ready_q <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_match = rsp_match_q;
  assign busy      = busy_q;

endmodule
